// File: rtl/cds_seq_generator.sv
// -----------------------------------------------------------------------------
// cds_seq_generator
//
// Purpose:
//   Correlated-double-sampling strobe generator. After each accepted rising
//   edge of the integrator-reset trigger it produces NUM_PHASES independent
//   strobes. Strobe k starts delay_us[k] microseconds after the trigger edge.
//   Every strobe stays high for width_us microseconds. When the last strobe has
//   finished, cds_done pulses for one cycle so the ADC capture logic can act.
//   Delays and width are converted to clock ticks (TICKS_PER_US clocks per us)
//   and latched when the run starts. Later input changes do not disturb a run
//   that is already in progress.
//
// Parameters:
//   NUM_PHASES    number of strobes (1..8)
//   CNT_W         width of each microsecond delay/width field
//   TICKS_PER_US  clk cycles per microsecond
//
// Ports:
//   clk          in   ADC clock; all logic on rising edge
//   reset        in   asynchronous, active-high; clears all state
//   trigger      in   integrator reset; a run starts on its rising edge
//   enable       in   when low, trigger edges seen in IDLE are ignored
//   delay_us     in   phase k delay in bits [k*CNT_W +: CNT_W]
//   width_us     in   high time shared by all phases
//   clr_overrun  in   synchronous clear of the overrun flag
//   cds_clk      out  registered strobes, one bit per phase
//   cds_done     out  one-cycle pulse after the last strobe has ended
//   busy         out  high from cycle 1 of a run through the cds_done cycle
//   overrun      out  sticky; a trigger edge arrived while a run was active
//
// Configuration:
//   CDS_RETRIGGER_EN  when defined, an enabled trigger edge during RUN or DONE
//                     restarts the sequence from a new cycle 0. The outputs of
//                     the aborted run are dropped. overrun is still set.
//                     When undefined, such edges are ignored and only set
//                     overrun.
// -----------------------------------------------------------------------------
module cds_seq_generator #(
  parameter int NUM_PHASES   = 2,
  parameter int CNT_W        = 16,
  parameter int TICKS_PER_US = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic                        enable,
  input  logic [NUM_PHASES*CNT_W-1:0] delay_us,
  input  logic [CNT_W-1:0]            width_us,
  input  logic                        clr_overrun,
  output logic [NUM_PHASES-1:0]       cds_clk,
  output logic                        cds_done,
  output logic                        busy,
  output logic                        overrun
);

  // One spare bit above the largest product, so that delay + width in ticks
  // can never wrap.
  localparam int TW = CNT_W + $clog2(TICKS_PER_US) + 1;
  localparam logic [TW-1:0] TICKS = TW'(TICKS_PER_US);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    trigger_dly_q, trigger_dly_d;
  logic                    trig_armed_q, trig_armed_d;
  logic [TW-1:0]           elapsed_q, elapsed_d;
  logic [TW-1:0]           dly_ticks_q [NUM_PHASES];
  logic [TW-1:0]           dly_ticks_d [NUM_PHASES];
  logic [TW-1:0]           wid_ticks_q, wid_ticks_d;
  logic [TW-1:0]           end_ticks_q, end_ticks_d;
  logic [NUM_PHASES-1:0]   cds_clk_q, cds_clk_d;
  logic                    overrun_q, overrun_d;

  // Tick values that would be latched if a run started in this cycle.
  logic [TW-1:0]           new_dly [NUM_PHASES];
  logic [TW-1:0]           new_wid;
  logic [TW-1:0]           new_end;

  logic                    trig_rise;
  logic                    start;
  logic                    restart;

  // Convert the microsecond inputs to ticks. The run length is the latest end
  // time over all phases. With a zero width, that is simply the largest delay.
  always_comb begin
    new_wid = TW'(width_us) * TICKS;
    new_end = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      new_dly[k] = TW'(delay_us[k*CNT_W +: CNT_W]) * TICKS;
      if (new_dly[k] + new_wid > new_end) begin
        new_end = new_dly[k] + new_wid;
      end
    end
  end

  // The trigger is already synchronous, so a single delay flop gives the
  // edge. The armed flag blocks a start until trigger has been seen low after
  // reset. Without it, a trigger held high through reset would look like a
  // fresh edge.
  always_comb begin
    trigger_dly_d = trigger;
    trig_armed_d  = trig_armed_q | ~trigger;
    trig_rise     = trigger & ~trigger_dly_q & trig_armed_q;
  end

  // Next-state logic for the sequencer. A start (from IDLE, or a restart
  // when retriggering is built in) latches fresh tick values and jumps to
  // elapsed = 1. A run whose end time is zero has nothing to strobe. Such a
  // run goes straight to DONE, so cds_done lands on cycle 1.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    wid_ticks_d = wid_ticks_q;
    end_ticks_d = end_ticks_q;
    for (int k = 0; k < NUM_PHASES; k++) begin
      dly_ticks_d[k] = dly_ticks_q[k];
    end
    overrun_d = overrun_q;
    start     = 1'b0;
    restart   = 1'b0;
    cds_clk_d = '0;

    case (state_q)
      IDLE: begin
        if (trig_rise && enable) begin
          start = 1'b1;
        end
      end
      RUN, DONE: begin
`ifdef CDS_RETRIGGER_EN
        if (trig_rise && enable) begin
          start   = 1'b1;
          restart = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        dly_ticks_d[k] = new_dly[k];
      end
      wid_ticks_d = new_wid;
      end_ticks_d = new_end;
      elapsed_d   = {{(TW-1){1'b0}}, 1'b1};
      state_d     = (new_end == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          elapsed_d = elapsed_q + 1'b1;
          if (elapsed_q == end_ticks_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          elapsed_d = '0;
          state_d   = IDLE;
        end
        default: begin
        end
      endcase
    end

    // Clear first, so a set in the same cycle wins.
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (trig_rise && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Strobes are registered from the next elapsed value, so cds_clk[k] is
    // high in exactly those cycles whose count lies in (D_k, D_k + W]. On a
    // restart, every strobe drops for the first cycle of the new run.
    for (int k = 0; k < NUM_PHASES; k++) begin
      cds_clk_d[k] = (state_d == RUN) && !restart &&
                     (elapsed_d > dly_ticks_d[k]) &&
                     (elapsed_d <= dly_ticks_d[k] + wid_ticks_d);
    end
  end

  // State registers. Reset takes everything back to IDLE with outputs low
  // at once, which abandons any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      trigger_dly_q <= 1'b0;
      trig_armed_q  <= 1'b0;
      elapsed_q     <= '0;
      wid_ticks_q   <= '0;
      end_ticks_q   <= '0;
      cds_clk_q     <= '0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        dly_ticks_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      trigger_dly_q <= trigger_dly_d;
      trig_armed_q  <= trig_armed_d;
      elapsed_q     <= elapsed_d;
      wid_ticks_q   <= wid_ticks_d;
      end_ticks_q   <= end_ticks_d;
      cds_clk_q     <= cds_clk_d;
      overrun_q     <= overrun_d;
      for (int k = 0; k < NUM_PHASES; k++) begin
        dly_ticks_q[k] <= dly_ticks_d[k];
      end
    end
  end

  // busy and cds_done decode the registered state directly, so they fall
  // together with the strobes when reset is asserted.
  always_comb begin
    cds_clk  = cds_clk_q;
    overrun  = overrun_q;
    busy     = (state_q != IDLE);
    cds_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_cds_seq_generator.sv
// -----------------------------------------------------------------------------
// tb_cds_seq_generator
//
// Testbench for cds_seq_generator with NUM_PHASES=2, CNT_W=16, TICKS_PER_US=20.
// The expected strobe windows, busy span and cds_done cycle of each run are
// worked out from the microsecond settings. Each window is D_k+1..D_k+W ticks
// after the trigger edge, and the run ends at max(D_k+W)+1. Inputs are driven
// on the falling edge, and outputs are sampled on the next falling edge.
// -----------------------------------------------------------------------------
module tb_cds_seq_generator;

   localparam int NP  = 2;
   localparam int CW  = 16;
   localparam int TPU = 20;

   logic              clk = 1'b0;
   logic              reset;
   logic              trigger;
   logic              enable;
   logic [NP*CW-1:0]  delay_us;
   logic [CW-1:0]     width_us;
   logic              clr_overrun;
   logic [NP-1:0]     cds_clk;
   logic              cds_done;
   logic              busy;
   logic              overrun;

   int   tests_run    = 0;
   int   tests_failed = 0;
   logic ovExp;

   cds_seq_generator #(
      .NUM_PHASES  (NP),
      .CNT_W       (CW),
      .TICKS_PER_US(TPU)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .trigger    (trigger),
      .enable     (enable),
      .delay_us   (delay_us),
      .width_us   (width_us),
      .clr_overrun(clr_overrun),
      .cds_clk    (cds_clk),
      .cds_done   (cds_done),
      .busy       (busy),
      .overrun    (overrun)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Drives one set of control inputs across a single rising edge, then
   // returns on the following falling edge so that outputs can be sampled.
   task automatic applyStimulus(input logic trig, input logic en, input logic clr);
      trigger     = trig;
      enable      = en;
      clr_overrun = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compares one observed value against its expected value.
   task automatic checkValue(input string tag, input int n, input logic [7:0] obs,
                             input logic [7:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   // Compares all four output groups for one cycle.
   task automatic checkOutput(input int n, input logic [1:0] expClk, input logic expDone,
                              input logic expBusy, input logic expOv);
      checkValue("cds_clk",  n, 8'(cds_clk),  8'(expClk));
      checkValue("cds_done", n, 8'(cds_done), 8'(expDone));
      checkValue("busy",     n, 8'(busy),     8'(expBusy));
      checkValue("overrun",  n, 8'(overrun),  8'(expOv));
   endtask

   // Runs one sequence from a trigger edge and checks every cycle.
   // retrigAt > 0 puts a second trigger edge at that cycle and holds trigger
   // high afterwards. resetAt > 0 asserts reset at that cycle.
   task automatic runSequence(input int d0, input int d1, input int w,
                              input int retrigAt, input int resetAt);
      int dt0, dt1, wt, e, lastEnd, rel;
      logic [1:0] ec;
      dt0 = d0 * TPU;
      dt1 = d1 * TPU;
      wt  = w * TPU;
      e   = ((dt0 > dt1) ? dt0 : dt1) + wt;
      lastEnd = e + 1;
`ifdef CDS_RETRIGGER_EN
      if (retrigAt > 0) lastEnd = retrigAt + e + 1;
`endif
      delay_us = {16'(d1), 16'(d0)};
      width_us = 16'(w);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int n = 1; n <= lastEnd + 1; n++) begin
         rel = n;
`ifdef CDS_RETRIGGER_EN
         if (retrigAt > 0 && n > retrigAt) rel = n - retrigAt;
`endif
         ec[0] = (rel >= dt0 + 1) && (rel <= dt0 + wt) && (n <= lastEnd);
         ec[1] = (rel >= dt1 + 1) && (rel <= dt1 + wt) && (n <= lastEnd);
`ifdef CDS_RETRIGGER_EN
         if (retrigAt > 0 && n == retrigAt + 1) ec = 2'b00;
`endif
         if (retrigAt > 0 && n == retrigAt + 1) ovExp = 1'b1;
         checkOutput(n, ec, logic'(n == lastEnd), logic'(n <= lastEnd), ovExp);
         if (n == resetAt) begin
            reset = 1'b1;
            #1;
            ovExp = 1'b0;
            checkOutput(n, 2'b00, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            reset = 1'b0;
            checkOutput(n, 2'b00, 1'b0, 1'b0, 1'b0);
            return;
         end
         if (retrigAt == 0) begin
            delay_us = 32'($urandom);
            width_us = 16'($urandom);
            applyStimulus(1'b0, 1'($urandom), 1'b0);
         end else begin
            applyStimulus(logic'(n >= retrigAt), 1'b1, 1'b0);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      trigger     = 1'b0;
      enable      = 1'b0;
      clr_overrun = 1'b0;
      delay_us    = '0;
      width_us    = '0;
      ovExp       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput(0, 2'b00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      // Nominal, overlapping, zero-width and all-zero sequences.
      runSequence(2, 10, 1, 0, 0);
      runSequence(3, 3, 2, 0, 0);
      runSequence(0, 5, 0, 0, 0);
      runSequence(0, 0, 0, 0, 0);

      // Second edge at cycle 100. Trigger stays high afterwards, which must
      // not start a new run.
      runSequence(2, 10, 1, 100, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput(1000 + i, 2'b00, 1'b0, 1'b0, ovExp);
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      ovExp = 1'b0;
      checkOutput(2000, 2'b00, 1'b0, 1'b0, 1'b0);

      // Reset mid-run, then a clean run with nominal timing.
      runSequence(2, 10, 1, 0, 50);
      applyStimulus(1'b0, 1'b1, 1'b0);
      runSequence(2, 10, 1, 0, 0);

      // A trigger edge with enable low produces no activity.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkOutput(3000 + i, 2'b00, 1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end

      // Trigger held high through reset must not start a run.
      trigger = 1'b1;
      reset   = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput(4000 + i, 2'b00, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);

      // Randomized settings with inputs scrambled during each run.
      for (int r = 0; r < 6; r++) begin
         runSequence(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)), 0, 0);
         applyStimulus(1'b0, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cds_seq_generator.md
Name: cds_seq_generator

Overview:
- Parametrised successor to the two-strobe CDS clock generator.
- Produces NUM_PHASES independent sampling strobes after each rising edge of the integrator-reset trigger. Each strobe has its own delay; all strobes share one width. Delays and width are given in microseconds and converted to clock ticks internally.
- Sits between the integrator-reset sequencer and the ADC capture logic. cds_done tells the ADC that the last strobe has finished.
- New versus the previous generation: N phases, overlapping phases allowed, edge-triggered start, sticky overrun flag, enable gating.

Parameters:
- NUM_PHASES, 2, number of CDS strobes (1..8).
- CNT_W, 16, width of each delay/width field in us.
- TICKS_PER_US, 20, clk cycles per microsecond.

Ports:
- clk  in  1  ADC clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- trigger  in  1  integrator reset; sequence starts on its rising edge; already synchronous to clk.
- enable  in  1  when low, rising edges of trigger in IDLE are ignored.
- delay_us  in  NUM_PHASES*CNT_W  phase k delay in bits [k*CNT_W +: CNT_W].
- width_us  in  CNT_W  high time shared by all phases.
- clr_overrun  in  1  synchronous clear of overrun.
- cds_clk  out  NUM_PHASES  strobes.
- cds_done  out  1  one-cycle pulse after the sequence ends.
- busy  out  1  high from cycle 1 of a run through the cds_done cycle.
- overrun  out  1  sticky: a trigger edge arrived while busy.

Behaviour:
- Reset values: cds_clk=0, cds_done=0, busy=0, overrun=0, state=IDLE, trigger_d=0, elapsed=0.
- Edge detect: trig_rise = trigger & ~trigger_d. trigger_d is registered every cycle, in every state.
- Cycle numbering: cycle 0 is the clk edge where trig_rise=1 and the start is accepted.
- Start condition in IDLE: trig_rise & enable. At cycle 0:
  - Latch D_k = delay_us[k]*TICKS_PER_US and W = width_us*TICKS_PER_US.
  - Latch E = max over k of (D_k + W).
  - Input changes after cycle 0 do not affect the run in progress.
- Arithmetic: tick width TW = CNT_W + $clog2(TICKS_PER_US) + 1. Products and sums are computed at TW bits and never overflow. elapsed is a TW-bit counter.
- States:
  - IDLE: outputs low. On the start condition, go to RUN with elapsed=1 on the next cycle.
  - RUN: elapsed increments by 1 per cycle.
    - Registered output: cds_clk[k] is high exactly during cycles D_k+1 .. D_k+W inclusive.
    - Phases may overlap or coincide; each is evaluated independently.
    - When elapsed == E+1, go to DONE; cds_done is high in cycle E+1.
  - DONE: lasts 1 cycle (cycle E+1). cds_done=1, busy=1, all cds_clk=0. Next state is IDLE, with elapsed cleared.
- W=0: no strobe asserts. E = max D_k, and cds_done still pulses at cycle E+1.
- All delays 0 and W=0: cds_done at cycle 1.
- busy is high for cycles 1..E+1.
- trig_rise while busy or in DONE (macro off): the edge is ignored and overrun is set. clr_overrun clears overrun; if set and clear happen in the same cycle, set wins.
- enable deasserted mid-run: the run completes normally.
- Reset asserted mid-run: all outputs fall asynchronously and the run is abandoned. After reset deasserts, a trigger held high produces no start until it has gone low and risen again.

Optional Feature:
- Macro CDS_RETRIGGER_EN.
- Defined: trig_rise & enable in RUN or DONE restarts the sequence.
  - That cycle becomes the new cycle 0; inputs are relatched; all cds_clk go low on the next cycle.
  - cds_done of the aborted run is suppressed.
  - overrun is still set, to flag the restart.
- Undefined: mid-run trigger edges are ignored and only set overrun, as specified above.

Test Plan:
- TICKS_PER_US=20, NUM_PHASES=2, delay={2,10}, width=1, single trigger pulse -> cds_clk[0] high cycles 41..60; cds_clk[1] high cycles 201..220; cds_done at cycle 221; busy for cycles 1..221; overrun=0.
- Overlap: delay={3,3}, width=2 -> both strobes high on cycles 61..100 simultaneously; cds_done at cycle 101.
- width=0, delay={0,5} -> no strobe; cds_done at cycle 101. delay={0,0}, width=0 -> cds_done at cycle 1.
- Second trigger edge at cycle 100 of the first test, macro off -> the first sequence is unchanged and overrun=1 from cycle 101. Asserting clr_overrun clears it. Trigger held high after the run gives no new start.
- Reset asserted at cycle 50 of the first test -> cds_clk[0] low immediately; no cds_done; busy=0. A later clean trigger gives nominal timing. With enable=0, a trigger produces no activity.
- CDS_RETRIGGER_EN defined, second edge at cycle 100 -> cds_clk[1] never asserts in the first run; new cds_clk[0] high cycles 141..160 relative to the first edge; overrun=1; exactly one cds_done pulse, at cycle 321.
